// File: rtl/conv_result_collector.sv
// conv_result_collector: quantizes signed conv accumulator results to 8-bit
// pixels, queues one frame in a FIFO and lets the host read it out.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 arms collection of one frame (flushes FIFO)
//   result_in/valid       32-bit signed accumulator sample and qualifier
//   rd_en                 host read strobe
//   rd_data/rd_valid      popped pixel, registered, one-cycle valid pulse
//   fifo_empty/full/count FIFO status
//   busy, frame_done      COLLECT/DRAIN and DONE indicators
//   overflow              sticky: a sample was dropped on a full FIFO
module conv_result_collector #(
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned FRAME_OUTPUTS = 576,
   parameter int unsigned SHIFT         = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [31:0]               result_in,
   input  logic                      result_valid,
   input  logic                      rd_en,
   output logic [7:0]                rd_data,
   output logic                      rd_valid,
   output logic                      fifo_empty,
   output logic                      fifo_full,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      overflow
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned SCW = $clog2(FRAME_OUTPUTS + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic            q_valid_q, q_valid_d;
   logic [7:0]      q_data_q, q_data_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [SCW-1:0]  samples_q, samples_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      rd_data_q, rd_data_d;
   logic            rd_valid_q, rd_valid_d;
   logic            empty_q, empty_d, full_q, full_d;
   logic            busy_q, busy_d, done_q, done_d;
   logic [7:0]      mem_q [DEPTH];

   logic            wr_en_c, pop_c, full_c, q_in_collect_c;
   logic signed [31:0] shifted_c;
   logic [7:0]      quant_c;

   // Saturating quantizer: negatives clamp to 0, large values to 255
   always_comb begin
      shifted_c = $signed(result_in) >>> SHIFT;
      if (result_in[31])
         quant_c = 8'd0;
      else if (shifted_c > 32'sd255)
         quant_c = 8'hFF;
      else
         quant_c = shifted_c[7:0];
   end

   // Next-state, FIFO bookkeeping and registered outputs
   always_comb begin
      state_d    = state_q;
      q_valid_d  = result_valid && (state_q == COLLECT);
      q_data_d   = q_data_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      samples_d  = samples_q;
      overflow_d = overflow_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      wr_en_c    = 1'b0;

      full_c         = (count_q == CW'(DEPTH));
      pop_c          = rd_en && (count_q != '0);
      q_in_collect_c = q_valid_q && (state_q == COLLECT);

      if (q_valid_d)
         q_data_d = quant_c;

      if (start) begin
         // start overrides reads, writes and the pending quantized sample
         state_d    = COLLECT;
         q_valid_d  = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         samples_d  = '0;
         overflow_d = 1'b0;
      end else begin
         if (pop_c) begin
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + AW'(1);
         end
         if (q_in_collect_c) begin
            samples_d = samples_q + SCW'(1);
            // a same-cycle pop frees the slot even when full
            if (!full_c || pop_c) begin
               wr_en_c  = 1'b1;
               wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
               overflow_d = 1'b1;
            end
            if (samples_q == SCW'(FRAME_OUTPUTS - 1))
               state_d = DRAIN;
         end else if (state_q == DRAIN && count_q == '0) begin
            state_d = DONE;
         end
         if (wr_en_c && !pop_c)
            count_d = count_q + CW'(1);
         else if (!wr_en_c && pop_c)
            count_d = count_q - CW'(1);
      end

      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
      busy_d  = (state_d == COLLECT) || (state_d == DRAIN);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         q_valid_q  <= 1'b0;
         q_data_q   <= 8'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         samples_q  <= '0;
         overflow_q <= 1'b0;
         rd_data_q  <= 8'd0;
         rd_valid_q <= 1'b0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         q_valid_q  <= q_valid_d;
         q_data_q   <= q_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         samples_q  <= samples_d;
         overflow_q <= overflow_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Storage array; validity is tracked by the pointers, so no reset needed
   always_ff @(posedge clk) begin
      if (rst_n && wr_en_c)
         mem_q[wr_ptr_q] <= q_data_q;
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign fifo_empty = empty_q;
   assign fifo_full  = full_q;
   assign fifo_count = count_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Bench for conv_result_collector: directed scenarios plus randomized frames,
// all checked every cycle against a queue-based reference model.
module tb_conv_result_collector;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned FRAME = 20;
   localparam int unsigned SHIFT = 8;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] result_in;
   logic        result_valid;
   logic        rd_en;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        fifo_empty;
   logic        fifo_full;
   logic [4:0]  fifo_count;
   logic        busy;
   logic        frame_done;
   logic        overflow;

   conv_result_collector #(.DEPTH(DEPTH), .FRAME_OUTPUTS(FRAME), .SHIFT(SHIFT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .result_in(result_in),
      .result_valid(result_valid), .rd_en(rd_en), .rd_data(rd_data),
      .rd_valid(rd_valid), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .fifo_count(fifo_count), .busy(busy), .frame_done(frame_done),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 done
   int              m_phase;
   bit              m_pv;
   byte unsigned    m_pd;
   byte unsigned    m_q[$];
   int              m_samples;
   bit              m_ovf;
   bit              m_rdv;
   byte unsigned    m_rdd;

   function automatic byte unsigned quant(input logic [31:0] r);
      int v;
      v = $signed(r);
      if (v < 0) return 8'd0;
      v = v / (1 << SHIFT);
      if (v > 255) return 8'd255;
      return 8'(v);
   endfunction

   task automatic model_step();
      int  old_phase;
      int  sz;
      bit  pop;
      old_phase = m_phase;
      sz        = m_q.size();
      if (!rst_n) begin
         m_phase = 0; m_pv = 0; m_pd = 0; m_q.delete(); m_samples = 0;
         m_ovf = 0; m_rdv = 0; m_rdd = 0;
      end else if (start) begin
         m_phase = 1; m_pv = 0; m_q.delete(); m_samples = 0;
         m_ovf = 0; m_rdv = 0;
      end else begin
         pop   = rd_en && (sz > 0);
         m_rdv = pop;
         if (pop) m_rdd = m_q.pop_front();
         if (m_pv && old_phase == 1) begin
            if (sz < int'(DEPTH) || pop) m_q.push_back(m_pd);
            else m_ovf = 1;
            m_samples++;
            if (m_samples == int'(FRAME)) m_phase = 2;
         end else if (old_phase == 2 && sz == 0) begin
            m_phase = 3;
         end
         m_pv = result_valid && (old_phase == 1);
         if (m_pv) m_pd = quant(result_in);
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      check("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
      check("fifo_full",  32'(fifo_full),  32'(m_q.size() == int'(DEPTH)));
      check("busy",       32'(busy),       32'(m_phase == 1 || m_phase == 2));
      check("frame_done", 32'(frame_done), 32'(m_phase == 3));
      check("overflow",   32'(overflow),   32'(m_ovf));
      check("rd_valid",   32'(rd_valid),   32'(m_rdv));
      check("rd_data",    32'(rd_data),    32'(m_rdd));
   endtask

   // One clock: model consumes the driven inputs, then DUT sampled after the edge
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drive(input bit st, input bit rv, input logic [31:0] d, input bit rd);
      start = st; result_valid = rv; result_in = d; rd_en = rd;
      cycle();
   endtask

   function automatic logic [31:0] rand_res();
      int v;
      case ($urandom_range(0, 3))
         0: begin v = -int'($urandom_range(1, 100000)); return 32'(v); end
         1: return 32'($urandom_range(0, 65535));
         2: return 32'($urandom_range(65536, 1 << 24));
         default: return $urandom;
      endcase
   endfunction

   task automatic random_frame(input int budget);
      drive(1, 0, 0, 0);
      for (int i = 0; i < budget && !(m_phase == 3); i++)
         drive(0, ($urandom_range(0, 9) < 7), rand_res(), ($urandom_range(0, 9) < 4));
      check("rand_frame_done", 32'(frame_done), 32'd1);
   endtask

   logic [31:0] vec34 [4];
   logic [7:0]  exp34 [4];

   initial begin
      vec34[0] = 32'd4660; vec34[1] = 32'(-500); vec34[2] = 32'd131072; vec34[3] = 32'd255;
      exp34[0] = 8'h12;    exp34[1] = 8'h00;     exp34[2] = 8'hFF;       exp34[3] = 8'h00;

      rst_n = 0; start = 0; result_in = 0; result_valid = 0; rd_en = 0;
      m_phase = 0; m_pv = 0; m_pd = 0; m_samples = 0; m_ovf = 0; m_rdv = 0; m_rdd = 0;
      cycle(); cycle();
      check("rst_empty", 32'(fifo_empty), 32'd1);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      rst_n = 1;
      drive(0, 0, 0, 1);   // read on empty FIFO is ignored

      // Quantization directed vectors and FIFO order
      drive(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, vec34[i], 0);
      drive(0, 0, 0, 0);
      check("lat_count", 32'(fifo_count), 32'd4);
      drive(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 1);
         check("q34_valid", 32'(rd_valid), 32'd1);
         check("q34_data", 32'(rd_data), 32'(exp34[i]));
      end
      drive(0, 0, 0, 1);
      check("q34_empty_rd", 32'(rd_valid), 32'd0);

      // Overflow: full frame with no reads
      drive(1, 0, 0, 0);
      for (int i = 0; i < int'(FRAME); i++) drive(0, 1, rand_res(), 0);
      drive(0, 0, 0, 0); drive(0, 0, 0, 0);
      check("ovf_count", 32'(fifo_count), 32'd16);
      check("ovf_full", 32'(fifo_full), 32'd1);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_busy", 32'(busy), 32'd1);
      for (int i = 0; i < int'(DEPTH); i++) drive(0, 0, 0, 1);
      drive(0, 0, 0, 0); drive(0, 0, 0, 0);
      check("drain_empty", 32'(fifo_empty), 32'd1);
      check("drain_done", 32'(frame_done), 32'd1);

      // Same-cycle read and write on a full FIFO
      drive(1, 0, 0, 0);
      for (int i = 0; i < int'(DEPTH) + 1; i++) drive(0, 1, 32'(i + 1) << SHIFT, 0);
      check("rw_full_pre", 32'(fifo_count), 32'd16);
      drive(0, 0, 0, 1);
      check("rw_full_count", 32'(fifo_count), 32'd16);
      check("rw_full_ovf", 32'(overflow), 32'd0);
      check("rw_full_head", 32'(rd_data), 32'd1);
      for (int i = 0; i < int'(DEPTH); i++) drive(0, 0, 0, 1);
      check("rw_full_tail", 32'(rd_data), 32'd17);

      // result_valid ignored in IDLE and in DONE
      rst_n = 0; drive(0, 0, 0, 0); rst_n = 1;
      for (int i = 0; i < 3; i++) drive(0, 1, 32'h1234, 0);
      drive(0, 0, 0, 0);
      check("idle_ignored", 32'(fifo_count), 32'd0);
      random_frame(400);
      for (int i = 0; i < 3; i++) drive(0, 1, 32'h1234, 0);
      drive(0, 0, 0, 0);
      check("done_ignored", 32'(fifo_count), 32'd0);
      check("done_hold", 32'(frame_done), 32'd1);

      // Reset mid-frame, then a clean frame
      drive(1, 0, 0, 0);
      for (int i = 0; i < 7; i++) drive(0, 1, rand_res(), 0);
      rst_n = 0; drive(0, 1, 32'h5000, 1); rst_n = 1;
      check("midrst_count", 32'(fifo_count), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_rd_data", 32'(rd_data), 32'd0);
      random_frame(400);
      for (int i = 0; i < 40 && fifo_count != 0; i++) drive(0, 0, 0, 1);

      // start during DRAIN with 5 entries held
      drive(1, 0, 0, 0);
      for (int i = 0; i < int'(FRAME); i++) drive(0, 1, rand_res(), 0);
      drive(0, 0, 0, 0); drive(0, 0, 0, 0);
      for (int i = 0; i < 40 && m_q.size() > 5; i++) drive(0, 0, 0, 1);
      check("pre_restart_count", 32'(fifo_count), 32'd5);
      drive(1, 0, 0, 1);
      check("restart_count", 32'(fifo_count), 32'd0);
      check("restart_ovf", 32'(overflow), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_no_rd", 32'(rd_valid), 32'd0);

      // Randomized frames
      for (int f = 0; f < 6; f++) random_frame(600);
      for (int i = 0; i < 40; i++) drive(0, 0, 0, ($urandom_range(0, 1) == 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_result_collector.md
CONV_RESULT_COLLECTOR -- requirements
Module: conv_result_collector

Interface
REQ-001 Parameter DEPTH, default 16: result FIFO depth in entries, power of two, at least 4.
REQ-002 Parameter FRAME_OUTPUTS, default 576: conv outputs per frame (24x24).
REQ-003 Parameter SHIFT, default 8: arithmetic right-shift applied to each accumulator result, range 0..23.
REQ-004 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 start  in  1  Nios pulse; arms collection of one frame.
REQ-007 result_in  in  32  signed accumulator result from conv PE.
REQ-008 result_valid  in  1  result_in qualifier, one sample per asserted cycle.
REQ-009 rd_en  in  1  Nios read strobe.
REQ-010 rd_data  out  8  quantized unsigned pixel, registered.
REQ-011 rd_valid  out  1  rd_data qualifier, one-cycle pulse.
REQ-012 fifo_empty / fifo_full  out  1 each  FIFO status.
REQ-013 fifo_count  out  clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-014 busy  out  1  high in COLLECT or DRAIN.
REQ-015 frame_done  out  1  high in DONE.
REQ-016 overflow  out  1  sticky, sample dropped on full FIFO.

Function
REQ-017 State machine SHALL have states IDLE, COLLECT, DRAIN, DONE.
REQ-018 start in any state SHALL flush the FIFO, clear the sample counter, clear overflow, and enter COLLECT next cycle; start has priority over every other event in that cycle, including rd_en.
REQ-019 Input stage: result_in SHALL be captured only when result_valid=1 and state=COLLECT; otherwise ignored.
REQ-020 Quantization, one register stage (q_valid, q_data): negative -> 0; else result_in >>> SHIFT; value >255 -> 255.
REQ-021 Each q_valid in COLLECT SHALL increment the sample counter and write q_data to the FIFO, or, if the FIFO is full and no read pops that cycle, drop it and set overflow.
REQ-022 q_valid outside COLLECT SHALL be discarded and not counted.
REQ-023 COLLECT -> DRAIN when q_valid and counter = FRAME_OUTPUTS-1.
REQ-024 DRAIN -> DONE when fifo_count = 0.
REQ-025 DONE SHALL hold until start or reset.
REQ-026 Read: rd_en with fifo_count>0 SHALL pop the head; rd_data and rd_valid=1 appear next cycle.
REQ-027 rd_en on empty FIFO SHALL be ignored: rd_valid=0, rd_data holds.
REQ-028 Read and write in the same cycle SHALL both succeed, fifo_count unchanged, including when full.
REQ-029 Reads SHALL be honoured in every state.
REQ-030 FIFO order SHALL be strict first-in first-out; pointers wrap modulo DEPTH.
REQ-031 Write-to-read latency: a sample accepted at cycle N is readable, fifo_empty=0, at cycle N+2.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force state IDLE, FIFO empty, counter 0, q_valid 0, rd_data 0x00, rd_valid 0, fifo_empty 1, fifo_full 0, fifo_count 0, busy 0, frame_done 0, overflow 0.
REQ-033 Reset mid-frame SHALL abandon the frame; no FIFO contents survive.

Verification
REQ-034 start, then result_in 4660, -500, 131072, 255 with SHIFT=8, then 4 reads -> rd_data 0x12, 0x00, 0xFF, 0x00 in that order, each with a one-cycle rd_valid pulse.
REQ-035 FRAME_OUTPUTS=20, DEPTH=16, 20 back-to-back results, no reads -> fifo_full=1, fifo_count=16, overflow=1, state DRAIN; 16 reads -> fifo_empty=1, frame_done=1.
REQ-036 FIFO full, rd_en and q_valid in the same cycle -> fifo_count stays 16, overflow stays 0, and the popped and written values are in correct order.
REQ-037 result_valid pulsed while in IDLE, then in DONE -> fifo_count=0, counter unchanged.
REQ-038 rst_n=0 after 7 of 576 samples -> all outputs at reset values next cycle; new start collects normally.
REQ-039 start during DRAIN with 5 entries held -> fifo_count=0, overflow=0, busy=1 next cycle.
